// File: rtl/prio_enc_seg_scan.sv
// Priority encoder with registered index/valid and a scanned common-anode hex display.
// Define PRIO_ENC_SEG_SYNC_EN to put 2-flop synchronisers on i_code and i_en.
module prio_enc_seg_scan #(
  parameter int N_IN     = 16,
  parameter int DIGITS   = 2,
  parameter int SCAN_DIV = 1000,
  localparam int CODE_W  = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [N_IN-1:0]   i_code,
  output logic [CODE_W-1:0] o_code,
  output logic              o_valid,
  output logic [7:0]        o_seg,
  output logic [DIGITS-1:0] o_dig_sel
);

  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DISP_W = 4 * DIGITS;
  localparam int EXT_W  = (CODE_W > DISP_W) ? CODE_W : DISP_W;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hFD;

  logic [N_IN-1:0]   enc_code;
  logic              enc_en;
  logic [CODE_W-1:0] enc_idx;
  logic              enc_any;

  logic [DIV_W-1:0]  div_cnt;
  logic [IDX_W-1:0]  dig_idx;
  logic              div_wrap;
  logic              idx_wrap;

  logic [EXT_W-1:0]  code_ext;
  logic [3:0]        cur_nibble;
  logic [7:0]        next_seg;

  // Input stage
`ifdef PRIO_ENC_SEG_SYNC_EN
  logic [N_IN-1:0] code_s1, code_s2;
  logic            en_s1, en_s2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      code_s1 <= '0;
      code_s2 <= '0;
      en_s1   <= 1'b0;
      en_s2   <= 1'b0;
    end else begin
      code_s1 <= i_code;
      code_s2 <= code_s1;
      en_s1   <= i_en;
      en_s2   <= en_s1;
    end
  end

  assign enc_code = code_s2;
  assign enc_en   = en_s2;
`else
  assign enc_code = i_code;
  assign enc_en   = i_en;
`endif

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    enc_idx = '0;
    enc_any = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (enc_code[i]) begin
        enc_idx = CODE_W'(i);
        enc_any = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_code  <= '0;
      o_valid <= 1'b0;
    end else begin
      o_code  <= (enc_en && enc_any) ? enc_idx : '0;
      o_valid <= enc_en && enc_any;
    end
  end

  // Digit scanner: each digit holds for SCAN_DIV cycles.
  assign div_wrap = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign idx_wrap = (dig_idx == IDX_W'(DIGITS - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_cnt <= '0;
      dig_idx <= '0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      dig_idx <= idx_wrap ? '0 : dig_idx + IDX_W'(1);
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  function automatic logic [7:0] hex_font(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = 8'h03;
      4'h1: seg = 8'h9F;
      4'h2: seg = 8'h25;
      4'h3: seg = 8'h0D;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h49;
      4'h6: seg = 8'h41;
      4'h7: seg = 8'h1F;
      4'h8: seg = 8'h01;
      4'h9: seg = 8'h09;
      4'hA: seg = 8'h11;
      4'hB: seg = 8'hC1;
      4'hC: seg = 8'h63;
      4'hD: seg = 8'h85;
      4'hE: seg = 8'h61;
      default: seg = 8'h71;
    endcase
    return seg;
  endfunction

  // Zero-extend so digits above the code width render as '0'.
  assign code_ext   = EXT_W'(o_code);
  assign cur_nibble = code_ext[{dig_idx, 2'b00} +: 4];

  always_comb begin
    next_seg = SEG_DASH;
    if (o_valid) begin
      next_seg = hex_font(cur_nibble);
    end
  end

  // Segments and select share one register stage and one dig_idx, so they never disagree.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_seg     <= SEG_BLANK;
      o_dig_sel <= '1;
    end else begin
      o_seg     <= next_seg;
      o_dig_sel <= ~(DIGITS'(1) << dig_idx);
    end
  end

endmodule
